// File: rtl/mac_pkg.sv
// Shared constants for the MAC sequencer, beat counter and datapath.
// Sequencer state encodings and the default beat count live here.
package mac_pkg;

    localparam int MAC_AW      = 4;
    localparam int MAC_CNT_NUM = 8;

    typedef logic [2:0] mac_state_t;

    localparam mac_state_t ST_IDLE = 3'd0;
    localparam mac_state_t ST_CLR  = 3'd1;
    localparam mac_state_t ST_RUN  = 3'd2;
    localparam mac_state_t ST_CHK  = 3'd3;
    localparam mac_state_t ST_DONE = 3'd4;

    // The beat counter must reach CNT_NUM-1 without wrapping.
    function automatic bit cnt_num_ok(input int cnt_num, input int aw);
        return (cnt_num >= 1) && (cnt_num <= (1 << aw) - 1);
    endfunction

endpackage

// File: rtl/mac_seq_if.sv
// Control/status bundle between the top-level controller and mac_seq.
// i_stall exists only when MAC_SEQ_STALL_EN is defined.
interface mac_seq_if #(
    parameter int AW = mac_pkg::MAC_AW
);
    logic          i_start;
    logic          i_cnt_f;
    logic          i_ack;
`ifdef MAC_SEQ_STALL_EN
    logic          i_stall;
`endif
    logic          o_busy;
    logic          o_rst_mac;
    logic          o_en;
    logic [AW-1:0] o_addr;
    logic          o_done;
    logic          o_err;

    modport master (
`ifdef MAC_SEQ_STALL_EN
        output i_stall,
`endif
        output i_start, i_cnt_f, i_ack,
        input  o_busy, o_rst_mac, o_en, o_addr, o_done, o_err
    );

    modport slave (
`ifdef MAC_SEQ_STALL_EN
        input  i_stall,
`endif
        input  i_start, i_cnt_f, i_ack,
        output o_busy, o_rst_mac, o_en, o_addr, o_done, o_err
    );

endinterface

// File: rtl/mac_beat_cnt.sv
// AW-bit beat counter with synchronous clear, enable and a terminal flag
// that marks the final beat (count == CNT_NUM-1).
module mac_beat_cnt #(
    parameter int CNT_NUM = mac_pkg::MAC_CNT_NUM,
    parameter int AW      = mac_pkg::MAC_AW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [AW-1:0] o_cnt,
    output logic          o_last
);
    localparam logic [AW-1:0] LAST = AW'(CNT_NUM - 1);

    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr)
            cnt_d = '0;
        else if (i_en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign o_cnt  = cnt_q;
    assign o_last = (cnt_q == LAST);

endmodule

// File: rtl/mac_seq.sv
// MAC operation sequencer: clear pulse, CNT_NUM enable beats, count-full check,
// held done. Optional per-beat stall input when MAC_SEQ_STALL_EN is defined.
module mac_seq
    import mac_pkg::*;
#(
    parameter int CNT_NUM = MAC_CNT_NUM,
    parameter int AW      = MAC_AW
) (
    input  logic       i_clk,
    input  logic       i_rst,
    mac_seq_if.slave   bus
);
    if (!cnt_num_ok(CNT_NUM, AW)) begin : g_bad_cnt_num
        $error("mac_seq: CNT_NUM must be in 1..2^AW-1");
    end

    mac_state_t    state_q, state_d;
    logic          rst_mac_q, rst_mac_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          en;
    logic          beat_clr;
    logic          beat_last;
    logic [AW-1:0] beat_cnt;

`ifdef MAC_SEQ_STALL_EN
    assign en = (state_q == ST_RUN) && !bus.i_stall;
`else
    assign en = (state_q == ST_RUN);
`endif
    assign beat_clr = (state_q == ST_CLR);

    mac_beat_cnt #(
        .CNT_NUM (CNT_NUM),
        .AW      (AW)
    ) u_beat_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (beat_clr),
        .i_en    (en),
        .o_cnt   (beat_cnt),
        .o_last  (beat_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.i_start) state_d = ST_CLR;
            ST_CLR:  state_d = ST_RUN;
            ST_RUN:  if (en && beat_last) state_d = ST_CHK;
            ST_CHK:  state_d = ST_DONE;
            ST_DONE: if (bus.i_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Error is sticky until the clear of the next operation; early full
        // in RUN or a missing full in CHK both set it.
        err_d = err_q;
        if (state_d == ST_CLR)
            err_d = 1'b0;
        if ((state_q == ST_RUN) && bus.i_cnt_f)
            err_d = 1'b1;
        if ((state_q == ST_CHK) && !bus.i_cnt_f)
            err_d = 1'b1;

        rst_mac_d = (state_d == ST_CLR);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            rst_mac_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_mac_q <= rst_mac_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_rst_mac = rst_mac_q;
    assign bus.o_en      = en;
    assign bus.o_addr    = beat_cnt;
    assign bus.o_done    = done_q;
    assign bus.o_err     = err_q;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with an expected-address scoreboard and a model
// downstream counter. Stall scenario runs only when MAC_SEQ_STALL_EN is defined.
module tb_mac_seq;
    import mac_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_seq_if #(.AW(MAC_AW)) bus ();

    mac_seq #(
        .CNT_NUM (N),
        .AW      (MAC_AW)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int addr_q[$];
    int beats;
    int mode;
    int stall_left;
    logic [4:0] model_cnt;

    // Model downstream counter: mode 0 normal, 1 withholds full, 2 full after 5 beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            model_cnt <= '0;
        else if (bus.o_rst_mac)
            model_cnt <= '0;
        else if (bus.o_en)
            model_cnt <= model_cnt + 5'd1;
    end

    always_comb begin
        bus.i_cnt_f = 1'b0;
        case (mode)
            1:       bus.i_cnt_f = 1'b0;
            2:       bus.i_cnt_f = (model_cnt >= 5'd5);
            default: bus.i_cnt_f = (model_cnt == 5'(N));
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
`ifdef MAC_SEQ_STALL_EN
        if (stall_left > 0) begin
            bus.i_stall = 1'b1;
            stall_left--;
        end else begin
            bus.i_stall = 1'b0;
        end
`endif
        #1;
`ifdef MAC_SEQ_STALL_EN
        if (bus.i_stall === 1'b1) begin
            check("stall_en", 32'(bus.o_en), 32'd0);
            check("stall_addr", 32'(bus.o_addr), 32'd2);
        end
`endif
        if (bus.o_en === 1'b1) begin
            beats++;
            if (addr_q.size() == 0)
                check("extra_beat", 32'd1, 32'd0);
            else
                check("beat_addr", 32'(bus.o_addr), 32'(addr_q.pop_front()));
        end
    endtask

    task automatic push_beats();
        addr_q.delete();
        for (int i = 0; i < N; i++) addr_q.push_back(i);
        beats = 0;
    endtask

    task automatic start_op();
        push_beats();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        check("clr_pulse", 32'(bus.o_rst_mac), 32'd1);
        check("clr_err", 32'(bus.o_err), 32'd0);
        check("clr_busy", 32'(bus.o_busy), 32'd1);
    endtask

    task automatic run_op(input int exp_lat, input logic exp_err,
                          input bit do_stall, input bit poke_start);
        int lat;
        bit stalled;
        stalled = 1'b0;
        start_op();
        lat = 1;
        while (bus.o_done !== 1'b1 && lat < 40) begin
            step();
            lat++;
            if (lat == 2) check("clr_once", 32'(bus.o_rst_mac), 32'd0);
            if (do_stall && !stalled && bus.o_en === 1'b1 && bus.o_addr == 1) begin
                stall_left = 3;
                stalled    = 1'b1;
            end
            bus.i_start = poke_start && (bus.o_en === 1'b1) && (bus.o_addr == 4);
        end
        bus.i_start = 1'b0;
        check("done_lat", 32'(lat), 32'(exp_lat));
        check("beats", 32'(beats), 32'(N));
        check("queue_empty", 32'(addr_q.size()), 32'd0);
        check("done_err", 32'(bus.o_err), 32'(exp_err));
        check("done_busy", 32'(bus.o_busy), 32'd1);
    endtask

    task automatic ack_op();
        bus.i_ack = 1'b1;
        step();
        bus.i_ack = 1'b0;
        check("ack_busy", 32'(bus.o_busy), 32'd0);
        check("ack_done", 32'(bus.o_done), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, "_rst_mac"}, 32'(bus.o_rst_mac), 32'd0);
        check({tag, "_en"}, 32'(bus.o_en), 32'd0);
        check({tag, "_addr"}, 32'(bus.o_addr), 32'd0);
        check({tag, "_done"}, 32'(bus.o_done), 32'd0);
        check({tag, "_err"}, 32'(bus.o_err), 32'd0);
    endtask

    initial begin
        int guard;
        rst         = 1'b1;
        mode        = 0;
        stall_left  = 0;
        beats       = 0;
        bus.i_start = 1'b0;
        bus.i_ack   = 1'b0;
`ifdef MAC_SEQ_STALL_EN
        bus.i_stall = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Nominal operation
        run_op(N + 3, 1'b0, 1'b0, 1'b0);
        ack_op();

        // Missing full in CHK, then cleared by the next start
        mode = 1;
        run_op(N + 3, 1'b1, 1'b0, 1'b0);
        ack_op();
        check("err_sticky_idle", 32'(bus.o_err), 32'd1);
        mode = 0;
        run_op(N + 3, 1'b0, 1'b0, 1'b0);
        ack_op();

        // Early full after 5 beats
        mode = 2;
        run_op(N + 3, 1'b1, 1'b0, 1'b0);
        ack_op();
        mode = 0;

        // Start ignored in RUN and DONE; ack+start together acknowledges only
        run_op(N + 3, 1'b0, 1'b0, 1'b1);
        bus.i_start = 1'b1;
        step();
        check("done_ignore_start", 32'(bus.o_done), 32'd1);
        check("done_no_clr", 32'(bus.o_rst_mac), 32'd0);
        bus.i_ack = 1'b1;
        step();
        bus.i_ack   = 1'b0;
        bus.i_start = 1'b0;
        check("ack_start_idle", 32'(bus.o_busy), 32'd0);
        repeat (3) step();
        check("no_restart_busy", 32'(bus.o_busy), 32'd0);
        check("no_restart_clr", 32'(bus.o_rst_mac), 32'd0);
        run_op(N + 3, 1'b0, 1'b0, 1'b0);
        ack_op();

        // Asynchronous reset on the 4th beat
        start_op();
        guard = 0;
        while (!(bus.o_en === 1'b1 && bus.o_addr == 3) && guard < 20) begin
            step();
            guard++;
        end
        check("reach_beat4", 32'(guard < 20), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        addr_q.delete();
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", 32'(bus.o_busy), 32'd0);
        run_op(N + 3, 1'b0, 1'b0, 1'b0);
        ack_op();

`ifdef MAC_SEQ_STALL_EN
        // Three stalled cycles at the third beat
        run_op(N + 6, 1'b0, 1'b1, 1'b0);
        ack_op();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
